multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle MIPS-subset core: decodes op/funct and generates
//  every datapath control, including the 3-bit alu_control consumed by the ALU.
//  Also consumes the ALU zero flag to resolve branches.
//  Sits between the instruction register and the datapath muxes/enables.
// PARAMETERS
//  none: encodings are fixed and held in the shared package.
// PORTS
//  clk          in   1  single clock; all state updates on posedge
//  rst          in   1  asynchronous, active-high reset
//  op           in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag (result of srcA+~srcB+1 == 0)
//  iord         out  1  memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1  data memory write strobe
//  ir_write     out  1  instruction register load
//  reg_dst      out  1  write-register select: 0=rt, 1=rd
//  mem_to_reg   out  1  write-back data select: 0=ALUOut, 1=MDR
//  reg_write    out  1  register file write strobe
//  alu_srcA     out  1  0=PC, 1=regA
//  alu_srcB     out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=imm<<2
//  alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  pc_en        out  1  PC load = pc_write | (branch & zero)
// BEHAVIOUR
//  - Moore FSM with one state register; all outputs combinational from state
//    (plus funct for alu_control, zero for pc_en). Reset forces FETCH immediately.
//  - Default output values in every state: all 0, with alu_control=010.
//    In FETCH, which is also the reset state, the outputs are:
//    ir_write=1, alu_srcB=01, alu_control=010, pc_src=00, pc_en=1.
//  - States and transitions:
//    FETCH -> DECODE
//    DECODE: alu_srcB=11, ADD (branch target). Next state is chosen by op:
//      lw 100011 or sw 101011 -> MEMADR
//      R-type 000000 -> EXECUTE
//      beq 000100 -> BRANCH
//      addi 001000 -> ADDIEX
//      j 000010 -> JUMP
//      any other op -> FETCH (executes as a nop)
//    MEMADR: alu_srcA=1, alu_srcB=10, ADD. Goes to MEMRD if op=lw, else MEMWR.
//    MEMRD: iord=1 -> MEMWB
//    MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH
//    MEMWR: iord=1, mem_write=1 -> FETCH
//    EXECUTE: alu_srcA=1, alu_srcB=00, alu_control decoded from funct -> ALUWB
//    ALUWB: reg_write=1, reg_dst=1 -> FETCH.
//      If funct is illegal, reg_write is held at 0.
//    BRANCH: alu_srcA=1, alu_srcB=00, SUB, pc_src=01, branch=1;
//      pc_en=zero -> FETCH
//    ADDIEX: alu_srcA=1, alu_srcB=10, ADD -> ADDIWB
//    ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH
//    JUMP: pc_src=10, pc_en=1 -> FETCH
//  - Funct decode in EXECUTE:
//    add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000;
//    or 100101 -> 001; slt 101010 -> 111.
//    Any other funct -> 010, and the illegal flag is set internally.
//  - Latency per instruction, in cycles: lw 5; sw, R-type and addi 4; beq and j 3.
//  - pc_en is asserted only in FETCH, JUMP, and in BRANCH when zero=1. Never elsewhere.
//  - The illegal flag is registered in EXECUTE, used in ALUWB, and cleared in FETCH.
//  - Reset mid-instruction: state returns to FETCH asynchronously.
//    No write strobe may glitch high while rst=1; all strobes are 0 in reset.
//  - op and funct must be stable from DECODE until the end of the instruction.
//    The IR loads only in FETCH.
// STRUCTURE
//  - Package core_ctrl_pkg holds:
//    op and funct localparams; ALU_AND/OR/ADD/SUB/SLT codes (shared with the ALU);
//    ALUSRCB_* and PCSRC_* codes; the 4-bit state encoding.
//  - One sub-module, alu_decoder:
//    combinational (aluop[1:0], funct) -> (alu_control, illegal_funct).
//    aluop: 00=ADD, 01=SUB, 10=use funct. The FSM drives aluop, not raw codes.
// TESTING
//  - Reset: assert rst mid-MEMRD.
//    Next sample shows FETCH outputs, with mem_write=0 and reg_write=0.
//  - lw (op=100011): state walk is FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
//    iord=1 in MEMRD; reg_write=1 with mem_to_reg=1 only in MEMWB.
//  - R-type sub (funct=100010): alu_control=110 in EXECUTE.
//    ALUWB has reg_write=1 and reg_dst=1. Total of 4 cycles.
//    Repeat for slt -> 111, and -> 000, or -> 001.
//  - beq with zero=1: pc_en=1 and pc_src=01 in BRANCH.
//    With zero=0: pc_en=0. Both cases return to FETCH after 3 cycles.
//  - j (op=000010): pc_src=10 and pc_en=1 in JUMP.
//    Unknown op 111111: DECODE -> FETCH with no write strobes.
//  - Illegal funct 000001: alu_control=010, and ALUWB has reg_write=0.
//    Back-to-back addi then sw gives 4+4 cycles, and write strobes appear only
//    in ADDIWB and MEMWR.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path.
// Holds opcode/funct values, ALU operation codes (also used by the ALU),
// mux select codes, the FSM state encoding and the bundled control word.
package core_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // FSM-to-decoder ALU request
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Mux select codes
  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encoding
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXECUTE = 4'd6;
  localparam logic [3:0] ST_ALUWB   = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_ADDIEX  = 4'd9;
  localparam logic [3:0] ST_ADDIWB  = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;

  // Control word produced by the FSM for one state
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_srcA;
    logic [1:0] alu_srcB;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
//   master: controller side (reads op/funct/zero, drives all controls)
//   slave : datapath side (drives op/funct/zero, reads all controls)
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_srcA;
  logic [1:0] alu_srcB;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       pc_en;

  modport master (
    input  op, funct, zero,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_srcA, alu_srcB, alu_control, pc_src, pc_en
  );

  modport slave (
    output op, funct, zero,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_srcA, alu_srcB, alu_control, pc_src, pc_en
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's aluop request (and funct for R-type) to the
// 3-bit ALU operation code.
//   i_aluop         in  2  00=ADD, 01=SUB, 10=decode funct
//   i_funct         in  6  IR[5:0]
//   o_alu_control   out 3  ALU operation
//   o_illegal_funct out 1  funct not recognised while decoding funct
module alu_decoder
  import core_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_funct
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_alu_control   = ALU_ADD;
    o_illegal_funct = 1'b0;
    case (i_aluop)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alu_control = ALU_ADD;
          FUNCT_SUB: o_alu_control = ALU_SUB;
          FUNCT_AND: o_alu_control = ALU_AND;
          FUNCT_OR:  o_alu_control = ALU_OR;
          FUNCT_SLT: o_alu_control = ALU_SLT;
          default:   o_illegal_funct = 1'b1;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS-subset core.
//   clk  in  1  clock, state updates on posedge
//   rst  in  1  asynchronous active-high reset, forces FETCH
//   bus  master modport: op/funct/zero in; iord, mem_write, ir_write,
//        reg_dst, mem_to_reg, reg_write, alu_srcA, alu_srcB, alu_control,
//        pc_src, pc_en out
// Outputs depend only on state, except alu_control (funct) and pc_en (zero).
module multicycle_controller
  import core_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;
  ctrl_t      w_ctrl;
  logic [2:0] w_alu_control;
  logic       w_illegal_funct;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      // Capture funct legality while EXECUTE decodes it; ALUWB consumes it.
      if (r_state == ST_EXECUTE) r_illegal <= w_illegal_funct;
      else if (r_state == ST_FETCH) r_illegal <= 1'b0;
    end
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH: w_next = ST_DECODE;
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE:     w_next = ST_EXECUTE;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_ADDI:      w_next = ST_ADDIEX;
          OP_J:         w_next = ST_JUMP;
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:  w_next = (bus.op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   w_next = ST_MEMWB;
      ST_EXECUTE: w_next = ST_ALUWB;
      ST_ADDIEX:  w_next = ST_ADDIWB;
      default:    w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.ir_write = 1'b1;
        w_ctrl.alu_srcB = ALUSRCB_FOUR;
        w_ctrl.pc_src   = PCSRC_ALU;
        w_ctrl.pc_write = 1'b1;
      end
      // Precompute the branch target while the register file is read.
      ST_DECODE: w_ctrl.alu_srcB = ALUSRCB_IMMSH;
      ST_MEMADR, ST_ADDIEX: begin
        w_ctrl.alu_srcA = 1'b1;
        w_ctrl.alu_srcB = ALUSRCB_IMM;
      end
      ST_MEMRD: w_ctrl.iord = 1'b1;
      ST_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      ST_EXECUTE: begin
        w_ctrl.alu_srcA = 1'b1;
        w_ctrl.alu_srcB = ALUSRCB_REGB;
        w_ctrl.aluop    = ALUOP_FUNCT;
      end
      // An unrecognised funct suppresses the register write.
      ST_ALUWB: begin
        w_ctrl.reg_write = ~r_illegal;
        w_ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        w_ctrl.alu_srcA = 1'b1;
        w_ctrl.alu_srcB = ALUSRCB_REGB;
        w_ctrl.aluop    = ALUOP_SUB;
        w_ctrl.pc_src   = PCSRC_ALUOUT;
        w_ctrl.branch   = 1'b1;
      end
      ST_ADDIWB: w_ctrl.reg_write = 1'b1;
      ST_JUMP: begin
        w_ctrl.pc_src   = PCSRC_JUMP;
        w_ctrl.pc_write = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_aluop         (w_ctrl.aluop),
    .i_funct         (bus.funct),
    .o_alu_control   (w_alu_control),
    .o_illegal_funct (w_illegal_funct)
  );

  assign bus.iord        = w_ctrl.iord;
  assign bus.mem_write   = w_ctrl.mem_write;
  assign bus.ir_write    = w_ctrl.ir_write;
  assign bus.reg_dst     = w_ctrl.reg_dst;
  assign bus.mem_to_reg  = w_ctrl.mem_to_reg;
  assign bus.reg_write   = w_ctrl.reg_write;
  assign bus.alu_srcA    = w_ctrl.alu_srcA;
  assign bus.alu_srcB    = w_ctrl.alu_srcB;
  assign bus.alu_control = w_alu_control;
  assign bus.pc_src      = w_ctrl.pc_src;
  assign bus.pc_en       = w_ctrl.pc_write | (w_ctrl.branch & bus.zero);

endmodule
